sb_tx_arbiter: RTL and testbench
================================

// Module: sb_tx_arbiter
// PURPOSE
//  Shares the single sideband TX path (encoder + framer FSM) among NUM_REQ message requesters
//  (e.g. LTSM, RDI, FDI) and one start-pattern requester. Picks one request at a time, drives
//  the TX path's request inputs, and waits for the TX path to finish. Then it acks the winner.
//  Sits between the link-training/adapter message sources and the sideband TX FSM.
// PARAMETERS
//  NUM_REQ     3    number of message requesters (2..8)
//  INFO_W      32   width of per-request message info (opcode/msgcode/msginfo bundle)
//  DATA_W      64   width of per-request data payload
//  TIMEOUT     255  cycles to wait for i_tx_busy / i_pattern_done before abort (8-bit counter)
//  GAP_CYC     2    idle cycles forced between consecutive grants (>=1)
// PORTS
//  i_clk              in   1               clock
//  i_rst              in   1               synchronous reset, active-high
//  i_req              in   NUM_REQ         level request per requester; held until o_ack
//  i_req_has_data     in   NUM_REQ         request carries data payload
//  i_req_info         in   NUM_REQ*INFO_W  packed message info; stable while i_req high
//  i_req_data         in   NUM_REQ*DATA_W  packed payload; stable while i_req high
//  i_pattern_req      in   1               start-pattern request (level)
//  o_ack              out  NUM_REQ         1-cycle pulse: message fully sent
//  o_pattern_ack      out  1               1-cycle pulse: pattern done
//  o_msg_valid        out  1               1-cycle pulse to TX path: start message
//  o_data_valid       out  1               with o_msg_valid: message has data
//  o_msg_info         out  INFO_W          muxed info of the granted requester, held during grant
//  o_msg_data         out  DATA_W          muxed data of the granted requester, held during grant
//  o_start_pattern_req out 1               1-cycle pulse to TX path: start pattern
//  i_tx_busy          in   1               TX path busy (message in flight)
//  i_pattern_done     in   1               TX path pattern complete (pulse)
//  o_grant_id         out  $clog2(NUM_REQ) index of current message grant
//  o_timeout_err      out  1               1-cycle pulse on watchdog abort
// BEHAVIOUR
//  - Reset (i_rst high at a clock edge): state=IDLE, RR pointer=0, counters=0. All outputs are 0.
//    This applies mid-operation too: no ack is issued for an aborted grant.
//  - States: IDLE, PATTERN, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
//  - IDLE:
//    - i_pattern_req wins over any i_req. Go to PATTERN and pulse o_start_pattern_req next cycle.
//    - Otherwise, if |i_req, do a round-robin pick starting at the RR pointer.
//      Latch the grant id, info and data. Go to ISSUE.
//  - ISSUE (1 cycle): o_msg_valid=1, o_data_valid=i_req_has_data[grant]. Then go to WAIT_BUSY.
//    Request-to-o_msg_valid latency = 2 cycles.
//  - WAIT_BUSY: wait for i_tx_busy=1, then go to WAIT_DONE.
//  - WAIT_DONE: on i_tx_busy falling (1 then 0), pulse o_ack[grant] and go to GAP.
//    RR pointer = grant+1, wrapping NUM_REQ-1 -> 0.
//  - PATTERN: on i_pattern_done, pulse o_pattern_ack and go to GAP.
//  - GAP: stay GAP_CYC cycles, then go to IDLE. No new grant is issued during GAP.
//  - Watchdog: 8-bit counter cleared on entry to WAIT_BUSY or PATTERN.
//    In WAIT_BUSY or PATTERN, if count reaches TIMEOUT, pulse o_timeout_err and go to GAP.
//    No ack is issued and the RR pointer still advances. WAIT_DONE has no timeout.
//  - Grant info/data are registered at grant time. Requester changes after grant are ignored.
//  - A requester dropping i_req before ack is a protocol violation. The grant completes anyway.
//  - Simultaneous events:
//    - i_pattern_req with i_req in IDLE: pattern served first; message served after GAP.
//    - i_tx_busy already 1 in ISSUE: WAIT_BUSY exits on its first cycle.
//  - o_msg_valid, o_start_pattern_req, o_ack, o_pattern_ack and o_timeout_err are all
//    registered, 1-cycle pulses.
// STRUCTURE
//  - sb_pkg:
//    - arb_state_e enum (3-bit)
//    - SB_INFO_W / SB_DATA_W defaults
//    - TIMEOUT_W = 8
//  - Sub-module sb_rr_arbiter: combinational round-robin pick from (req vector, pointer)
//    to (onehot grant, index, any).
//  - Top holds the FSM, watchdog, gap counter, payload registers and output registers.
// TESTING
//  1. Single message: i_req=3'b010, has_data=1, info=0xA5A5_0001.
//     -> o_msg_valid+o_data_valid 2 cycles later, o_msg_info=0xA5A5_0001.
//     Then busy high 5 cycles, then low -> o_ack=3'b010 one cycle.
//  2. Round-robin: i_req=3'b111 held, each acked after busy pulse -> grant order 0,1,2,0.
//     Ack spacing >= GAP_CYC+busy+3 cycles.
//  3. Pattern priority: i_pattern_req and i_req[0] rise together.
//     -> o_start_pattern_req first; after i_pattern_done, o_pattern_ack.
//     Then after GAP, o_msg_valid for requester 0.
//  4. Watchdog: grant with i_tx_busy never asserted -> o_timeout_err at TIMEOUT=255 cycles
//     after WAIT_BUSY entry. No o_ack; next grant goes to the next requester.
//  5. Reset mid-op: assert i_rst during WAIT_DONE -> next cycle all outputs 0, state IDLE.
//     After release with i_req=3'b001 -> grant 0 (pointer reset).
//  6. Wrap: NUM_REQ=3, pointer=2, i_req=3'b101 -> grant 2, then 0.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and widths for the sideband TX arbiter slice.
package sb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PATTERN   = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } arb_state_e;

  localparam int SB_INFO_W = 32;
  localparam int SB_DATA_W = 64;
  localparam int TIMEOUT_W = 8;

endpackage

// File: rtl/sb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module sb_rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sb_tx_arbiter.sv
// Shares the sideband TX path between NUM_REQ message requesters and the
// start-pattern requester; one grant at a time, with watchdog and forced idle gap.
module sb_tx_arbiter
  import sb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int INFO_W  = SB_INFO_W,
  parameter int DATA_W  = SB_DATA_W,
  parameter int TIMEOUT = 255,
  parameter int GAP_CYC = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ-1:0]         i_req_has_data,
  input  logic [NUM_REQ*INFO_W-1:0]  i_req_info,
  input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
  input  logic                       i_pattern_req,
  output logic [NUM_REQ-1:0]         o_ack,
  output logic                       o_pattern_ack,
  output logic                       o_msg_valid,
  output logic                       o_data_valid,
  output logic [INFO_W-1:0]          o_msg_info,
  output logic [DATA_W-1:0]          o_msg_data,
  output logic                       o_start_pattern_req,
  input  logic                       i_tx_busy,
  input  logic                       i_pattern_done,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  arb_state_e           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant_q;
  logic                 has_data_q;
  logic [INFO_W-1:0]    info_q;
  logic [DATA_W-1:0]    data_q;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [TIMEOUT_W-1:0] wd_nxt;
  logic                 wd_expired;
  logic [GAP_W-1:0]     gap_cnt;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [INFO_W-1:0]    pick_info;
  logic [DATA_W-1:0]    pick_data;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + IDX_W'(1);
  endfunction

  sb_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (i_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    pick_info = '0;
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        pick_info = i_req_info[i*INFO_W +: INFO_W];
        pick_data = i_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wd_nxt     = wd_cnt + TIMEOUT_W'(1);
  assign wd_expired = (wd_nxt == TIMEOUT_W'(TIMEOUT));

  // Grant payload is captured once in IDLE and held for the whole grant.
  assign o_msg_info = info_q;
  assign o_msg_data = data_q;
  assign o_grant_id = grant_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state               <= ST_IDLE;
      rr_ptr              <= '0;
      grant_q             <= '0;
      has_data_q          <= 1'b0;
      info_q              <= '0;
      data_q              <= '0;
      wd_cnt              <= '0;
      gap_cnt             <= '0;
      o_ack               <= '0;
      o_pattern_ack       <= 1'b0;
      o_msg_valid         <= 1'b0;
      o_data_valid        <= 1'b0;
      o_start_pattern_req <= 1'b0;
      o_timeout_err       <= 1'b0;
    end else begin
      o_ack               <= '0;
      o_pattern_ack       <= 1'b0;
      o_msg_valid         <= 1'b0;
      o_data_valid        <= 1'b0;
      o_start_pattern_req <= 1'b0;
      o_timeout_err       <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_pattern_req) begin
            state               <= ST_PATTERN;
            o_start_pattern_req <= 1'b1;
            wd_cnt              <= '0;
          end else if (pick_any) begin
            state      <= ST_ISSUE;
            grant_q    <= pick_idx;
            has_data_q <= |(i_req_has_data & pick_gnt);
            info_q     <= pick_info;
            data_q     <= pick_data;
          end
        end
        ST_ISSUE: begin
          o_msg_valid  <= 1'b1;
          o_data_valid <= has_data_q;
          wd_cnt       <= '0;
          state        <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (i_tx_busy) begin
            state <= ST_WAIT_DONE;
          end else begin
            wd_cnt <= wd_nxt;
            if (wd_expired) begin
              // Abandon the grant without ack, but still move the pointer on.
              o_timeout_err <= 1'b1;
              rr_ptr        <= ptr_after(grant_q);
              gap_cnt       <= '0;
              state         <= ST_GAP;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (!i_tx_busy) begin
            o_ack   <= NUM_REQ'(1) << grant_q;
            rr_ptr  <= ptr_after(grant_q);
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_PATTERN: begin
          if (i_pattern_done) begin
            o_pattern_ack <= 1'b1;
            gap_cnt       <= '0;
            state         <= ST_GAP;
          end else begin
            wd_cnt <= wd_nxt;
            if (wd_expired) begin
              o_timeout_err <= 1'b1;
              gap_cnt       <= '0;
              state         <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter: a table of single-message grants plus
// hand sequences for round-robin, pattern priority, watchdog and mid-grant reset.
module tb_sb_tx_arbiter;

  localparam int NUM_REQ = 3;
  localparam int INFO_W  = 32;
  localparam int DATA_W  = 64;

  logic                      i_clk = 1'b0;
  logic                      i_rst;
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ-1:0]        i_req_has_data;
  logic [NUM_REQ*INFO_W-1:0] i_req_info;
  logic [NUM_REQ*DATA_W-1:0] i_req_data;
  logic                      i_pattern_req;
  logic [NUM_REQ-1:0]        o_ack;
  logic                      o_pattern_ack;
  logic                      o_msg_valid;
  logic                      o_data_valid;
  logic [INFO_W-1:0]         o_msg_info;
  logic [DATA_W-1:0]         o_msg_data;
  logic                      o_start_pattern_req;
  logic                      i_tx_busy;
  logic                      i_pattern_done;
  logic [1:0]                o_grant_id;
  logic                      o_timeout_err;

  sb_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .INFO_W(INFO_W), .DATA_W(DATA_W), .TIMEOUT(255), .GAP_CYC(2)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_req              (i_req),
    .i_req_has_data     (i_req_has_data),
    .i_req_info         (i_req_info),
    .i_req_data         (i_req_data),
    .i_pattern_req      (i_pattern_req),
    .o_ack              (o_ack),
    .o_pattern_ack      (o_pattern_ack),
    .o_msg_valid        (o_msg_valid),
    .o_data_valid       (o_data_valid),
    .o_msg_info         (o_msg_info),
    .o_msg_data         (o_msg_data),
    .o_start_pattern_req(o_start_pattern_req),
    .i_tx_busy          (i_tx_busy),
    .i_pattern_done     (i_pattern_done),
    .o_grant_id         (o_grant_id),
    .o_timeout_err      (o_timeout_err)
  );

  always #5 i_clk = ~i_clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  hd;
    logic [31:0] info;
    int          busy;
    int          gnt;
    logic        dv;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic ev(input int sel);
    case (sel)
      0:       return o_msg_valid;
      1:       return |o_ack;
      2:       return o_pattern_ack;
      3:       return o_timeout_err;
      default: return 1'b0;
    endcase
  endfunction

  // Returns the number of clock edges until the event, or -1 if the bound expired.
  task automatic wait_ev(input int sel, input int bound, input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ev(sel) && n < bound);
    if (!ev(sel)) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: event %0d not seen within %0d cycles", name, sel, bound);
      n = -1;
    end
  endtask

  task automatic do_reset();
    i_rst          = 1'b1;
    i_req          = '0;
    i_req_has_data = '0;
    i_req_info     = '0;
    i_req_data     = '0;
    i_pattern_req  = 1'b0;
    i_tx_busy      = 1'b0;
    i_pattern_done = 1'b0;
    repeat (2) tick();
    i_rst = 1'b0;
  endtask

  // The expected winner's slot carries info/{info,~info}; other slots carry decoys.
  task automatic drive_req(input logic [2:0] req, input logic [2:0] hd,
                           input logic [31:0] info, input int slot);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == slot) begin
        i_req_info[i*INFO_W +: INFO_W] = info;
        i_req_data[i*DATA_W +: DATA_W] = {info, ~info};
      end else begin
        i_req_info[i*INFO_W +: INFO_W] = ~info ^ 32'(i);
        i_req_data[i*DATA_W +: DATA_W] = {~info, info ^ 32'(i + 1)};
      end
    end
    i_req_has_data = hd;
    i_req          = req;
  endtask

  task automatic run_msg(input logic [2:0] req, input logic [2:0] hd, input logic [31:0] info,
                         input int busy, input int gnt, input logic dv, input string tag);
    int n;
    drive_req(req, hd, info, gnt);
    wait_ev(0, 10, {tag, "_mv"}, n);
    if (n >= 0) begin
      chk({tag, "_lat"}, 64'(n), 64'(2));
      chk({tag, "_dv"}, 64'(o_data_valid), 64'(dv));
      chk({tag, "_gid"}, 64'(o_grant_id), 64'(gnt));
      chk({tag, "_info"}, 64'(o_msg_info), 64'(info));
      chk({tag, "_data"}, o_msg_data, {info, ~info});
      i_req_info     = ~i_req_info;
      i_req_data     = ~i_req_data;
      i_req_has_data = ~i_req_has_data;
      i_tx_busy      = 1'b1;
      for (int b = 0; b < busy; b++) begin
        tick();
        if (b == 0) chk({tag, "_mvpulse"}, 64'(o_msg_valid), 64'(0));
      end
      i_tx_busy = 1'b0;
      wait_ev(1, 6, {tag, "_ack"}, n);
      if (n >= 0) begin
        chk({tag, "_acklat"}, 64'(n), 64'(1));
        chk({tag, "_ackvec"}, 64'(o_ack), 64'(3'b001 << gnt));
        chk({tag, "_hold"}, 64'(o_msg_info), 64'(info));
      end
      i_req = '0;
      tick();
      chk({tag, "_ackpulse"}, 64'(o_ack), 64'(0));
      tick();
    end
  endtask

  initial begin
    int n;
    int last_ack;
    int exp_rr [4];

    tbl[0] = '{req: 3'b010, hd: 3'b010, info: 32'hA5A5_0001, busy: 5, gnt: 1, dv: 1'b1};
    tbl[1] = '{req: 3'b101, hd: 3'b100, info: 32'h1234_5678, busy: 2, gnt: 2, dv: 1'b1};
    tbl[2] = '{req: 3'b101, hd: 3'b001, info: 32'h0BAD_F00D, busy: 3, gnt: 0, dv: 1'b1};
    tbl[3] = '{req: 3'b001, hd: 3'b000, info: 32'h1111_2222, busy: 1, gnt: 0, dv: 1'b0};
    tbl[4] = '{req: 3'b110, hd: 3'b100, info: 32'hDEAD_BEEF, busy: 2, gnt: 1, dv: 1'b0};
    tbl[5] = '{req: 3'b011, hd: 3'b011, info: 32'h5555_AAAA, busy: 4, gnt: 0, dv: 1'b1};
    tbl[6] = '{req: 3'b100, hd: 3'b000, info: 32'h0F0F_F0F0, busy: 1, gnt: 2, dv: 1'b0};
    tbl[7] = '{req: 3'b111, hd: 3'b111, info: 32'hCAFE_0007, busy: 2, gnt: 0, dv: 1'b1};

    // Reset state
    do_reset();
    chk("rst_ctl", 64'({o_ack, o_pattern_ack, o_msg_valid, o_data_valid,
                        o_start_pattern_req, o_timeout_err, o_grant_id}), 64'(0));
    chk("rst_info", 64'(o_msg_info), 64'(0));
    chk("rst_data", o_msg_data, 64'(0));

    // Table: pointer progression from reset 0 -> 2 -> 0 -> 1 -> 1 -> 2 -> 1 -> 0
    for (int k = 0; k < 8; k++)
      run_msg(tbl[k].req, tbl[k].hd, tbl[k].info, tbl[k].busy, tbl[k].gnt, tbl[k].dv,
              $sformatf("v%0d", k));

    // Round-robin with all three held
    do_reset();
    exp_rr = '{0, 1, 2, 0};
    for (int i = 0; i < NUM_REQ; i++) begin
      i_req_info[i*INFO_W +: INFO_W] = 32'hC0DE_0000 + 32'(i);
      i_req_data[i*DATA_W +: DATA_W] = 64'(i);
    end
    i_req    = 3'b111;
    last_ack = -100;
    for (int k = 0; k < 4; k++) begin
      int t;
      wait_ev(0, 10, $sformatf("rr%0d_mv", k), n);
      if (n < 0) break;
      chk($sformatf("rr%0d_lat", k), 64'(n), 64'((k == 0) ? 2 : 4));
      chk($sformatf("rr%0d_gid", k), 64'(o_grant_id), 64'(exp_rr[k]));
      chk($sformatf("rr%0d_info", k), 64'(o_msg_info), 64'(32'hC0DE_0000 + 32'(exp_rr[k])));
      t = n;
      i_tx_busy = 1'b1;
      repeat (2) tick();
      i_tx_busy = 1'b0;
      wait_ev(1, 6, $sformatf("rr%0d_ack", k), n);
      if (n < 0) break;
      t += 2 + n;
      chk($sformatf("rr%0d_ackvec", k), 64'(o_ack), 64'(3'b001 << exp_rr[k]));
      if (k > 0) chk($sformatf("rr%0d_spacing_ok", k), 64'(t >= 7), 64'(1));
      last_ack = t;
    end
    i_req = '0;
    repeat (3) tick();

    // Pattern wins over a simultaneous message request
    do_reset();
    drive_req(3'b001, 3'b001, 32'h7777_0000, 0);
    i_pattern_req = 1'b1;
    tick();
    chk("pat_start", 64'(o_start_pattern_req), 64'(1));
    chk("pat_no_msg", 64'(o_msg_valid), 64'(0));
    tick();
    chk("pat_start_pulse", 64'(o_start_pattern_req), 64'(0));
    repeat (2) tick();
    chk("pat_no_early_ack", 64'(o_pattern_ack), 64'(0));
    i_pattern_done = 1'b1;
    tick();
    i_pattern_done = 1'b0;
    i_pattern_req  = 1'b0;
    chk("pat_ack", 64'(o_pattern_ack), 64'(1));
    wait_ev(0, 10, "pat_msg_mv", n);
    if (n >= 0) begin
      chk("pat_msg_lat", 64'(n), 64'(4));
      chk("pat_msg_gid", 64'(o_grant_id), 64'(0));
      chk("pat_msg_info", 64'(o_msg_info), 64'(32'h7777_0000));
      i_tx_busy = 1'b1;
      tick();
      i_tx_busy = 1'b0;
      wait_ev(1, 6, "pat_msg_ack", n);
      if (n >= 0) chk("pat_msg_ackvec", 64'(o_ack), 64'(3'b001));
    end
    i_req = '0;
    repeat (3) tick();

    // Watchdog: busy never rises
    do_reset();
    drive_req(3'b011, 3'b000, 32'h9999_0000, 0);
    wait_ev(0, 10, "wd_mv", n);
    if (n >= 0) begin
      chk("wd_gid", 64'(o_grant_id), 64'(0));
      wait_ev(3, 400, "wd_terr", n);
      if (n >= 0) begin
        chk("wd_cycles", 64'(n), 64'(255));
        chk("wd_no_ack", 64'(o_ack), 64'(0));
        tick();
        chk("wd_terr_pulse", 64'(o_timeout_err), 64'(0));
        wait_ev(0, 10, "wd_next_mv", n);
        if (n >= 0) begin
          chk("wd_next_lat", 64'(n), 64'(3));
          chk("wd_next_gid", 64'(o_grant_id), 64'(1));
          i_tx_busy = 1'b1;
          tick();
          i_tx_busy = 1'b0;
          wait_ev(1, 6, "wd_next_ack", n);
          if (n >= 0) chk("wd_next_ackvec", 64'(o_ack), 64'(3'b010));
        end
      end
    end
    i_req = '0;
    repeat (3) tick();

    // Reset during WAIT_DONE; pointer must return to 0
    do_reset();
    run_msg(3'b001, 3'b000, 32'h4444_0001, 1, 0, 1'b0, "rp");
    drive_req(3'b010, 3'b010, 32'h4444_0002, 1);
    wait_ev(0, 10, "rm_mv", n);
    if (n >= 0) begin
      chk("rm_gid_pre", 64'(o_grant_id), 64'(1));
      i_tx_busy = 1'b1;
      repeat (2) tick();
      i_rst = 1'b1;
      tick();
      chk("rm_ctl", 64'({o_ack, o_pattern_ack, o_msg_valid, o_data_valid,
                         o_start_pattern_req, o_timeout_err, o_grant_id}), 64'(0));
      chk("rm_info", 64'(o_msg_info), 64'(0));
      i_rst     = 1'b0;
      i_tx_busy = 1'b0;
      drive_req(3'b011, 3'b000, 32'h4444_0003, 0);
      tick();
      chk("rm_no_ack", 64'(o_ack), 64'(0));
      wait_ev(0, 10, "rm_post_mv", n);
      if (n >= 0) chk("rm_post_gid", 64'(o_grant_id), 64'(0));
    end
    i_req = '0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
